// File: rtl/pipe_pkg.sv
// Shared constants for the inter-stage pipeline registers of the 5-stage core.
// Each stage's bubble carries a canonical NOP in the low instruction word.
package pipe_pkg;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    localparam int IF_ID_W  = 96;
    localparam int ID_EX_W  = 160;
    localparam int EX_MEM_W = 128;
    localparam int MEM_WB_W = 104;

    localparam logic [IF_ID_W-1:0]  IF_ID_BUBBLE  = {64'b0, RV_NOP};
    localparam logic [ID_EX_W-1:0]  ID_EX_BUBBLE  = {{(ID_EX_W-32){1'b0}}, RV_NOP};
    localparam logic [EX_MEM_W-1:0] EX_MEM_BUBBLE = {{(EX_MEM_W-32){1'b0}}, RV_NOP};
    localparam logic [MEM_WB_W-1:0] MEM_WB_BUBBLE = {{(MEM_WB_W-32){1'b0}}, RV_NOP};

endpackage

// File: rtl/pipe_slot.sv
// Single valid+data holding register with load and clear.
// Latency: load visible next cycle. Backpressure: none, the parent decides when to load.
// Clear and reset both drop the valid bit and return the data to BUBBLE_VAL.
module pipe_slot
    import pipe_pkg::*;
#(
    parameter int                 DATA_W     = IF_ID_W,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr_i,
    input  logic              load_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              vld_o,
    output logic [DATA_W-1:0] data_o
);

    logic              vld_q, vld_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        if (clr_i) begin
            vld_d  = 1'b0;
            data_d = BUBBLE_VAL;
        end else if (load_i) begin
            vld_d  = 1'b1;
            data_d = data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            data_q <= BUBBLE_VAL;
        end else begin
            vld_q  <= vld_d;
            data_q <= data_d;
        end
    end

    assign vld_o  = vld_q;
    assign data_o = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid entry and bubble output.
// Latency: 1 cycle push-to-output. Backpressure: SKID=1 absorbs one extra word and drives a
// registered in_ready; SKID=0 passes out_ready combinationally to in_ready.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                 DATA_W     = IF_ID_W,
    parameter logic [DATA_W-1:0]  BUBBLE_VAL = '0,
    parameter bit                 SKID       = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic              main_v, skid_v;
    logic [DATA_W-1:0] main_d, skid_d;
    logic              push, pop;
    logic              main_clr, main_ld, skid_clr, skid_ld;
    logic [DATA_W-1:0] main_din;

    assign push = in_valid && in_ready;
    assign pop  = main_v && out_ready;

    always_comb begin
        main_clr = 1'b0;
        main_ld  = 1'b0;
        skid_clr = 1'b0;
        skid_ld  = 1'b0;
        main_din = in_data;
        if (flush) begin
            main_clr = 1'b1;
            skid_clr = 1'b1;
        end else if (SKID) begin
            // Skid is always the younger word, so it refills main before any new push.
            if (skid_v && pop) begin
                main_ld  = 1'b1;
                main_din = skid_d;
                skid_clr = 1'b1;
            end else if (!main_v || pop) begin
                main_ld  = push;
                main_clr = !push;
            end else if (push) begin
                skid_ld = 1'b1;
            end
        end else begin
            main_ld  = push;
            main_clr = pop && !push;
        end
    end

    pipe_slot #(.DATA_W(DATA_W), .BUBBLE_VAL(BUBBLE_VAL)) u_main (
        .clk    (clk),
        .rst    (rst),
        .clr_i  (main_clr),
        .load_i (main_ld),
        .data_i (main_din),
        .vld_o  (main_v),
        .data_o (main_d)
    );

    generate
        if (SKID) begin : g_skid
            logic in_rdy_q, skid_v_nxt;

            pipe_slot #(.DATA_W(DATA_W), .BUBBLE_VAL(BUBBLE_VAL)) u_skid (
                .clk    (clk),
                .rst    (rst),
                .clr_i  (skid_clr),
                .load_i (skid_ld),
                .data_i (in_data),
                .vld_o  (skid_v),
                .data_o (skid_d)
            );

            // Ready is a flop of the skid's next valid, so no ready-to-ready comb path exists.
            assign skid_v_nxt = skid_clr ? 1'b0 : (skid_ld ? 1'b1 : skid_v);

            always_ff @(posedge clk) begin
                if (rst) begin
                    in_rdy_q <= 1'b1;
                end else begin
                    in_rdy_q <= !skid_v_nxt;
                end
            end

            assign in_ready = in_rdy_q;
        end else begin : g_noskid
            assign skid_v   = 1'b0;
            assign skid_d   = BUBBLE_VAL;
            assign in_ready = !main_v || out_ready;
        end
    endgenerate

    assign out_valid = main_v;
    assign out_data  = main_v ? main_d : BUBBLE_VAL;
    assign occupancy = {1'b0, main_v} + {1'b0, skid_v};

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: directed vector table, hand sequences and a queue-model random run.
module tb_pipe_stage_reg;
    import pipe_pkg::*;

    localparam logic [95:0] BUB1 = IF_ID_BUBBLE;
    localparam logic [31:0] BUB0 = RV_NOP;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    // SKID=1 instance (IF/ID width)
    logic        rst1, flush1, iv1, ir1, ov1, or1;
    logic [95:0] id1, od1;
    logic [1:0]  occ1;
    // SKID=0 instance (32-bit payload)
    logic        rst0, flush0, iv0, ir0, ov0, or0;
    logic [31:0] id0, od0;
    logic [1:0]  occ0;

    pipe_stage_reg #(.DATA_W(IF_ID_W), .BUBBLE_VAL(IF_ID_BUBBLE), .SKID(1'b1)) u1 (
        .clk(clk), .rst(rst1), .flush(flush1), .in_valid(iv1), .in_ready(ir1),
        .in_data(id1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .occupancy(occ1)
    );

    pipe_stage_reg #(.DATA_W(32), .BUBBLE_VAL(RV_NOP), .SKID(1'b0)) u0 (
        .clk(clk), .rst(rst0), .flush(flush0), .in_valid(iv0), .in_ready(ir0),
        .in_data(id0), .out_valid(ov0), .out_ready(or0), .out_data(od0), .occupancy(occ0)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            if (n_err <= 40)
                $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        rst, flush, iv;
        logic [95:0] d;
        logic        ordy;
        logic        e_ov;
        logic [95:0] e_d;
        logic        e_ir;
        logic [1:0]  e_occ;
    } vec_t;

    vec_t vt[15];

    function automatic vec_t mk(logic r, logic f, logic v, logic [95:0] d, logic o,
                                logic eov, logic [95:0] ed, logic eir, logic [1:0] eocc);
        vec_t x;
        x.rst = r; x.flush = f; x.iv = v; x.d = d; x.ordy = o;
        x.e_ov = eov; x.e_d = ed; x.e_ir = eir; x.e_occ = eocc;
        return x;
    endfunction

    logic [95:0] q1[$];
    logic [31:0] q0[$];

    initial begin
        rst1 = 1; flush1 = 0; iv1 = 0; id1 = '0; or1 = 0;
        rst0 = 1; flush0 = 0; iv0 = 0; id0 = '0; or0 = 0;

        //         rst f  iv data            or   ov data   ir occ   (expected after the edge)
        vt[0]  = mk(1, 0, 1, {12{8'hAA}},    1,   0, BUB1,  1, 0);
        vt[1]  = mk(1, 0, 1, {12{8'hAA}},    1,   0, BUB1,  1, 0);
        vt[2]  = mk(0, 0, 1, 96'd1,          1,   1, 96'd1, 1, 1);
        vt[3]  = mk(0, 0, 1, 96'd2,          0,   1, 96'd1, 0, 2);
        vt[4]  = mk(0, 0, 1, 96'd3,          0,   1, 96'd1, 0, 2);
        vt[5]  = mk(0, 0, 1, 96'd3,          1,   1, 96'd2, 1, 1);
        vt[6]  = mk(0, 0, 1, 96'd3,          1,   1, 96'd3, 1, 1);
        vt[7]  = mk(0, 0, 0, 96'd0,          1,   0, BUB1,  1, 0);
        vt[8]  = mk(0, 0, 1, 96'h10,         0,   1, 96'h10, 1, 1);
        vt[9]  = mk(0, 0, 1, 96'h11,         0,   1, 96'h10, 0, 2);
        vt[10] = mk(0, 1, 1, 96'h55,         0,   0, BUB1,  1, 0);
        vt[11] = mk(0, 0, 0, 96'h0,          0,   0, BUB1,  1, 0);
        vt[12] = mk(0, 0, 1, 96'h20,         0,   1, 96'h20, 1, 1);
        vt[13] = mk(0, 0, 1, 96'h21,         0,   1, 96'h20, 0, 2);
        vt[14] = mk(1, 1, 1, 96'h22,         0,   0, BUB1,  1, 0);

        for (int i = 0; i < 15; i++) begin
            rst1 = vt[i].rst; flush1 = vt[i].flush; iv1 = vt[i].iv;
            id1 = vt[i].d; or1 = vt[i].ordy;
            tick();
            chk($sformatf("vec%0d out_valid", i), {95'b0, ov1}, {95'b0, vt[i].e_ov});
            chk($sformatf("vec%0d out_data", i), od1, vt[i].e_d);
            chk($sformatf("vec%0d in_ready", i), {95'b0, ir1}, {95'b0, vt[i].e_ir});
            chk($sformatf("vec%0d occupancy", i), {94'b0, occ1}, {94'b0, vt[i].e_occ});
        end
        rst1 = 0; flush1 = 0;

        // Streaming: one word per cycle, each visible one cycle after its push
        for (int k = 1; k <= 8; k++) begin
            iv1 = 1; id1 = 96'(k) << 40 | 96'(k); or1 = 1;
            #1;
            chk($sformatf("stream%0d in_ready", k), {95'b0, ir1}, 96'd1);
            tick();
            chk($sformatf("stream%0d out_data", k), od1, 96'(k) << 40 | 96'(k));
            chk($sformatf("stream%0d occ", k), {94'b0, occ1}, 96'd1);
        end
        iv1 = 0;
        tick();
        chk("stream drain out_valid", {95'b0, ov1}, 96'd0);

        // SKID=0: combinational ready and same-cycle pop+push
        rst0 = 1; tick(); tick(); rst0 = 0;
        chk("s0 reset in_ready", {95'b0, ir0}, 96'd1);
        chk("s0 reset out_data", {64'b0, od0}, {64'b0, BUB0});
        iv0 = 1; id0 = 32'hA1A1_0001; or0 = 0;
        tick();
        chk("s0 load out_data", {64'b0, od0}, 96'hA1A1_0001);
        iv0 = 1; id0 = 32'hB2B2_0002; or0 = 0;
        #1;
        chk("s0 stalled in_ready", {95'b0, ir0}, 96'd0);
        tick();
        chk("s0 stalled hold", {64'b0, od0}, 96'hA1A1_0001);
        or0 = 1;
        #1;
        chk("s0 release in_ready", {95'b0, ir0}, 96'd1);
        tick();
        chk("s0 replace out_data", {64'b0, od0}, 96'hB2B2_0002);
        chk("s0 replace occ", {94'b0, occ0}, 96'd1);
        iv0 = 0;
        tick();
        chk("s0 drain out_data", {64'b0, od0}, {64'b0, BUB0});

        // Random run against queue models for both modes
        rst1 = 1; rst0 = 1; tick(); rst1 = 0; rst0 = 0;
        q1.delete(); q0.delete();
        for (int c = 0; c < 10000; c++) begin
            logic f, v, o, exp_r1, exp_r0;
            logic [95:0] d;
            f = ($urandom_range(0, 99) < 4);
            v = ($urandom_range(0, 99) < 70);
            o = ($urandom_range(0, 99) < 60);
            d = {$urandom, $urandom, $urandom};
            flush1 = f; iv1 = v; or1 = o; id1 = d;
            flush0 = f; iv0 = v; or0 = o; id0 = d[31:0];
            #1;
            exp_r1 = (q1.size() < 2);
            exp_r0 = (q0.size() == 0) || o;
            chk("rnd s1 in_ready", {95'b0, ir1}, {95'b0, exp_r1});
            chk("rnd s0 in_ready", {95'b0, ir0}, {95'b0, exp_r0});
            if (f) begin
                q1.delete();
                q0.delete();
            end else begin
                if (o && q1.size() > 0) void'(q1.pop_front());
                if (v && exp_r1) q1.push_back(d);
                if (o && q0.size() > 0) void'(q0.pop_front());
                if (v && exp_r0) q0.push_back(d[31:0]);
            end
            tick();
            chk("rnd s1 occ", {94'b0, occ1}, 96'(q1.size()));
            chk("rnd s1 out_valid", {95'b0, ov1}, {95'b0, q1.size() > 0});
            chk("rnd s1 out_data", od1, (q1.size() > 0) ? q1[0] : BUB1);
            chk("rnd s0 occ", {94'b0, occ0}, 96'(q0.size()));
            chk("rnd s0 out_data", {64'b0, od0}, {64'b0, (q0.size() > 0) ? q0[0] : BUB0});
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised inter-stage pipeline register for the 5-stage RISC-V core. It generalises the fixed-width stall/flush latches between stages into one block with a valid/ready handshake, an optional two-entry skid buffer, and bubble injection. A bubble is a configurable NOP payload presented whenever the stage holds no valid instruction. It is instantiated between IF/ID, ID/EX, EX/MEM and MEM/WB, each with its own payload width.

## Interface
- DATA_W, 96 — payload width in bits; the IF/ID instance carries {PC_next, PC, instruction}.
- BUBBLE_VAL, {DATA_W{1'b0}} — value driven on out_data while out_valid=0, and the value loaded on reset or flush.
- SKID, 1 — 1 selects a two-entry skid buffer with registered in_ready; 0 selects a single entry with combinational in_ready.
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  synchronous kill of every held entry; this is the branch-taken/exception redirect.
- in_valid  in  1  upstream stage offers in_data.
- in_ready  out  1  stage can accept this cycle; this replaces a write-enable/stall input.
- in_data  in  DATA_W  upstream payload.
- out_valid  out  1  out_data holds a live instruction.
- out_ready  in  1  downstream consumes this cycle; low means the downstream stage is stalled.
- out_data  out  DATA_W  payload; equals BUBBLE_VAL whenever out_valid=0.
- occupancy  out  2  number of held entries, 0..2 (0..1 when SKID=0).

## Operation
- Storage is a main entry (main_v, main_d) and a skid entry (skid_v, skid_d). The skid entry is present only when SKID=1.
- Transfers:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
  - out_valid = main_v.
  - out_data = main_v ? main_d : BUBBLE_VAL.
- in_ready:
  - SKID=1: in_ready = !skid_v, and is a pure register output.
  - SKID=0: in_ready = !main_v || out_ready.
- SKID=1 next-state, in priority order:
  - rst or flush: main_v=0, skid_v=0, main_d=skid_d=BUBBLE_VAL. Flush discards a simultaneous push.
  - Skid full and pop: main takes skid, skid_v=0. No push can occur, because in_ready=0.
  - Main empty, or pop: main takes in_data if push, else main_v=0.
  - Main full, no pop, push: skid takes in_data, skid_v=1.
  - Otherwise hold. Held data never changes while out_ready=0.
- SKID=0: main loads on push, clears on pop without push, and holds otherwise.
- Order is preserved: the skid entry is always younger than the main entry.
- occupancy = main_v + skid_v.
- Invariant: skid_v=1 implies main_v=1.

## Timing
- Reset values: out_valid=0, out_data=BUBBLE_VAL, occupancy=0. in_ready=1 in both modes.
- Latency: a push in cycle N appears on out_data in cycle N+1.
- Throughput: one transfer per cycle while out_ready=1.
- Stall absorption (SKID=1): after out_ready falls, at most one further push is accepted. in_ready falls the following cycle. This gives upstream one full cycle to react, so there is no ready-to-ready combinational path.
- Recovery: the cycle out_ready returns high, main pops and skid moves to main. in_ready rises the next cycle.
- Flush while stalled: the stage empties next cycle regardless of out_ready, and in_ready=1 next cycle.
- Simultaneous flush and rst: identical effect.
- Reset mid-operation: both held entries are lost with no partial transfer.
- in_valid=1 with in_ready=0 has no effect. Upstream must hold in_data stable until the push occurs.

## Structure
- Shared package pipe_pkg holds:
  - RV_NOP = 32'h0000_0013 (addi x0,x0,0).
  - Per-stage payload width constants: IF_ID_W=96, ID_EX_W, EX_MEM_W, MEM_WB_W.
  - Bubble constants built from RV_NOP; for IF/ID this is {64'b0, RV_NOP}.
- One sub-module is natural: pipe_slot, a single valid+data register with load, clear and BUBBLE_VAL reset. It is instantiated once for main and once for skid under a SKID generate.
- The hazard unit drives flush. A load-use stall is expressed by deasserting out_ready of the IF/ID instance, or in_valid of the ID/EX instance, rather than through a separate write-enable.

## Test plan
- Reset: assert rst for 2 cycles with in_valid=1 and in_data=0xAA.. → out_valid=0, out_data=BUBBLE_VAL, in_ready=1, occupancy=0.
- Streaming: SKID=1, push words 1..8 on consecutive cycles with out_ready=1 → word k appears on out_data one cycle after its push, with no gaps and occupancy always ≤1.
- Stall absorption: stream 1,2,3 and drop out_ready in the cycle word 1 is at the output → word 2 lands in skid, in_ready=0 next cycle, occupancy=2. Raise out_ready → outputs 1,2,3 in order with nothing lost or duplicated.
- Flush versus push: occupancy=2, assert flush together with in_valid=1 and data 0x55 → next cycle out_valid=0, out_data=BUBBLE_VAL (NOP 0x00000013 in the low word), 0x55 dropped, in_ready=1.
- SKID=0 mode: main full and out_ready=0 → in_ready=0 in the same cycle. Set out_ready=1 together with in_valid=1 → pop and push happen in the same cycle, and the new word appears next cycle.
- Random: random in_valid, out_ready and flush against a reference queue model → order, occupancy and the bubble-value invariant hold for 10k cycles.
